// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave.
package spi_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;

    // Bit position that goes out on the wire first.
    function automatic int first_bit_idx(input bit lsbf, input int data_bits);
        return lsbf ? 0 : data_bits - 1;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall detect on the synced level.
module spi_in_sync
    import spi_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= {SYNC_STAGES{RST_VAL}};
            prev_reg  <= RST_VAL;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw};
            prev_reg  <= chain_reg[SYNC_STAGES-1];
        end
    end

    assign level = chain_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversamples SCK/SS/MOSI in the clk domain, shifts a buffered word out on MISO.
// Define SPI_SLAVE_UNDERRUN_EN to add the underrun pulse output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b1,
    parameter bit LSBF      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SCK,
    input  logic                 SS,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic                 underrun
`endif
);

    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam int               FIRST_IDX = first_bit_idx(LSBF, DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DATA_BITS - 1);
    // Synchronizer reset levels for {MOSI, SS, SCK}: SS idles high, SCK idles at CPOL.
    localparam logic [2:0]       SYNC_RST  = {1'b0, 1'b1, CPOL};

    logic [2:0] raw, lvl, rise, fall;
    assign raw = {MOSI, SS, SCK};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_in_sync #(.RST_VAL(SYNC_RST[gi])) u_sync (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[gi]),
            .level (lvl[gi]),
            .rise  (rise[gi]),
            .fall  (fall[gi])
        );
    end

    logic unused_sync;
    assign unused_sync = ^{lvl[1:0], rise[2], fall[2]};

    logic sck_lead, sck_trail, sample_edge, shift_edge, ss_rise, ss_fall, mosi_s;
    assign sck_lead    = CPOL ? fall[0] : rise[0];
    assign sck_trail   = CPOL ? rise[0] : fall[0];
    assign sample_edge = CPHA ? sck_trail : sck_lead;
    assign shift_edge  = CPHA ? sck_lead  : sck_trail;
    assign ss_rise     = rise[1];
    assign ss_fall     = fall[1];
    assign mosi_s      = lvl[2];

    spi_state_t           state_reg, state_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] tx_sh_reg, tx_sh_next;
    logic [DATA_BITS-1:0] rx_sh_reg, rx_sh_next;
    logic [DATA_BITS-1:0] buf_reg, buf_next;
    logic                 buf_full_reg, buf_full_next;
    logic                 tx_ready_reg;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 reload_reg, reload_next;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic                 underrun_reg, underrun_next;
`endif

    logic                 load, frame_start;
    logic [DATA_BITS-1:0] rx_word, tx_shifted;

    assign load       = tx_valid && tx_ready_reg;
    assign rx_word    = LSBF ? {mosi_s, rx_sh_reg[DATA_BITS-1:1]} : {rx_sh_reg[DATA_BITS-2:0], mosi_s};
    assign tx_shifted = LSBF ? {1'b0, tx_sh_reg[DATA_BITS-1:1]} : {tx_sh_reg[DATA_BITS-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            tx_ready_reg <= 1'b1;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            reload_reg   <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
            underrun_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_sh_reg    <= tx_sh_next;
            rx_sh_reg    <= rx_sh_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            tx_ready_reg <= !buf_full_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            reload_reg   <= reload_next;
`ifdef SPI_SLAVE_UNDERRUN_EN
            underrun_reg <= underrun_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_sh_next    = tx_sh_reg;
        rx_sh_next    = rx_sh_reg;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        reload_next   = reload_reg;
        frame_start   = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next   = ACTIVE;
                    bit_cnt_next = '0;
                    reload_next  = 1'b0;
                    frame_start  = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                    reload_next  = 1'b0;
                end else if (sample_edge) begin
                    rx_sh_next = rx_word;
                    if (bit_cnt_reg == LAST_CNT) begin
                        rx_data_next  = rx_word;
                        rx_valid_next = 1'b1;
                        bit_cnt_next  = '0;
                        reload_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else if (shift_edge) begin
                    // A back-to-back reload waits for the next shift edge with SS still low,
                    // so releasing SS after the last edge never starts a phantom frame.
                    if (bit_cnt_reg != '0) begin
                        tx_sh_next = tx_shifted;
                    end else if (reload_reg) begin
                        reload_next = 1'b0;
                        frame_start = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (frame_start) begin
            if (buf_full_reg) begin
                tx_sh_next    = buf_reg;
                buf_full_next = 1'b0;
            end else begin
                tx_sh_next    = '0;
`ifdef SPI_SLAVE_UNDERRUN_EN
                underrun_next = 1'b1;
`endif
            end
        end

        // Loads only happen while the buffer is empty, so they never collide with a take.
        if (load) begin
            buf_next      = tx_data;
            buf_full_next = 1'b1;
        end
    end

    assign MISO     = (state_reg == ACTIVE) ? tx_sh_reg[FIRST_IDX] : 1'b0;
    assign tx_ready = tx_ready_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
`ifdef SPI_SLAVE_UNDERRUN_EN
    assign underrun = underrun_reg;
`endif

endmodule
